compression: RTL

COMPRESSION -- requirements
Module: compression

---
 rtl/comp_pkg.sv | 34 +++
 rtl/compression_lane_pack.sv | 36 +++
 rtl/compression.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/comp_pkg.sv
// Shared constants and types for the 16-bit -> 10-bit sample compression path.
// The decompression side imports the same package.
//
// Contents:
//   LANE_W    : width of one unpacked input sample
//   PACK_W    : width of one packed sample
//   LANES     : samples per stream beat
//   BEATS_IN  : input beats per group
//   BEATS_OUT : output beats per group
//   GRP_BITS  : packed group width (BEATS_IN * LANES * PACK_W)
//   lane_ovf(): true when a sample does not fit in PACK_W bits
package comp_pkg;

  localparam int unsigned LANE_W    = 16;
  localparam int unsigned PACK_W    = 10;
  localparam int unsigned LANES     = 32;
  localparam int unsigned BEATS_IN  = 8;
  localparam int unsigned BEATS_OUT = 5;
  localparam int unsigned GRP_BITS  = 2560;

  // Stream beat width (same on both sides) and the packed width of one input beat.
  localparam int unsigned BEAT_W = LANES * LANE_W;
  localparam int unsigned SLOT_W = LANES * PACK_W;

  typedef enum logic [0:0] {
    StIdle,
    StSend
  } out_state_e;

  function automatic logic lane_ovf(input logic [LANE_W-1:0] sample);
    return |sample[LANE_W-1:PACK_W];
  endfunction

endpackage

// File: rtl/compression_lane_pack.sv
// Combinational packer for one input beat: 32 x 16-bit lanes -> 32 x 10-bit slots.
//
// Parameters:
//   SATURATE  : 0 keeps the low 10 bits of each sample, 1 clamps oversized samples to 10'h3FF
// Ports:
//   data_i    : 32 unpacked lanes, lane k at [k*16 +: 16]
//   pack_o    : 32 packed slots, lane k at [k*10 +: 10]
//   ovf_cnt_o : number of lanes with any of bits [15:10] set (0..32)
module compression_lane_pack
  import comp_pkg::*;
#(
  parameter int unsigned SATURATE = 0
) (
  input  logic [BEAT_W-1:0] data_i,
  output logic [SLOT_W-1:0] pack_o,
  output logic [5:0]        ovf_cnt_o
);

  always_comb begin
    pack_o    = '0;
    ovf_cnt_o = '0;
    for (int k = 0; k < int'(LANES); k++) begin
      if (lane_ovf(data_i[k*LANE_W +: LANE_W])) begin
        ovf_cnt_o = ovf_cnt_o + 6'd1;
        if (SATURATE != 0) begin
          pack_o[k*PACK_W +: PACK_W] = '1;
        end else begin
          pack_o[k*PACK_W +: PACK_W] = data_i[k*LANE_W +: PACK_W];
        end
      end else begin
        pack_o[k*PACK_W +: PACK_W] = data_i[k*LANE_W +: PACK_W];
      end
    end
  end

endmodule

// File: rtl/compression.sv
// Sample compression: packs groups of 8 input beats (256 x 16-bit samples) into
// 2560-bit groups of 10-bit samples and streams each group out as 5 beats, MSB-first.
// One group can wait in the accumulator while the previous one is being sent.
//
// Parameters:
//   SATURATE      : 0 truncates oversized samples, 1 clamps them to 10'h3FF
// Ports:
//   clk, rst_n    : clock and asynchronous active-low reset
//   s_axis_*      : input stream (tdata 32 x 16-bit lanes, tlast closes a group early)
//   m_axis_*      : output stream (tdata packed bits, tlast on beat 4 of a tlast-closed group)
//   short_grp     : one-cycle pulse after a group closes with fewer than 8 beats
//   ovf_cnt       : saturating count of samples with bits [15:10] nonzero
module compression
  import comp_pkg::*;
#(
  parameter int unsigned SATURATE = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BEAT_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic              s_axis_tlast,
  output logic [BEAT_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic              short_grp,
  output logic [15:0]       ovf_cnt
);

  out_state_e          state_q, state_d;
  logic [2:0]          out_cnt_q, out_cnt_d;
  logic [2:0]          in_cnt_q, in_cnt_d;
  logic [GRP_BITS-1:0] acc_q, acc_d;
  logic [GRP_BITS-1:0] obuf_q, obuf_d;
  logic [GRP_BITS-1:0] acc_merged;
  logic                acc_full_q, acc_full_d;
  logic                acc_last_q, acc_last_d;
  logic                obuf_last_q, obuf_last_d;
  logic                short_q, short_d;
  logic [15:0]         ovf_q, ovf_d;
  logic [16:0]         ovf_sum;

  logic [SLOT_W-1:0]   slot;
  logic [5:0]          beat_ovf;
  logic                hs_in, close, hs_out, last_out, out_free, xfer;

  compression_lane_pack #(
    .SATURATE (SATURATE)
  ) u_lane_pack (
    .data_i    (s_axis_tdata),
    .pack_o    (slot),
    .ovf_cnt_o (beat_ovf)
  );

  assign s_axis_tready = rst_n && !acc_full_q;
  assign hs_in         = s_axis_tvalid && s_axis_tready;
  assign close         = hs_in && (s_axis_tlast || (in_cnt_q == 3'(BEATS_IN - 1)));
  assign hs_out        = m_axis_tvalid && m_axis_tready;
  assign last_out      = hs_out && (out_cnt_q == 3'(BEATS_OUT - 1));
  // The output buffer can be reloaded when idle or on the edge its final beat leaves.
  assign out_free      = (state_q == StIdle) || last_out;
  // close and acc_full_q are exclusive: tready is low while a group is pending.
  assign xfer          = out_free && (close || acc_full_q);

  // Accumulator with the current beat written into its slot. Slots above the
  // current beat are still zero, which gives the zero fill for short groups.
  always_comb begin
    acc_merged = acc_q;
    for (int b = 0; b < int'(BEATS_IN); b++) begin
      if (in_cnt_q == 3'(b)) begin
        acc_merged[b*SLOT_W +: SLOT_W] = slot;
      end
    end
  end

  // Datapath next state.
  always_comb begin
    acc_d       = acc_q;
    acc_full_d  = acc_full_q;
    acc_last_d  = acc_last_q;
    obuf_d      = obuf_q;
    obuf_last_d = obuf_last_q;
    in_cnt_d    = in_cnt_q;

    if (hs_in) begin
      in_cnt_d = close ? 3'd0 : 3'(in_cnt_q + 3'd1);
    end

    if (acc_full_q) begin
      if (xfer) begin
        obuf_d      = acc_q;
        obuf_last_d = acc_last_q;
        acc_d       = '0;
        acc_full_d  = 1'b0;
        acc_last_d  = 1'b0;
      end
    end else if (close) begin
      if (xfer) begin
        obuf_d      = acc_merged;
        obuf_last_d = s_axis_tlast;
        acc_d       = '0;
      end else begin
        acc_d      = acc_merged;
        acc_full_d = 1'b1;
        acc_last_d = s_axis_tlast;
      end
    end else if (hs_in) begin
      acc_d = acc_merged;
    end

    short_d = close && (in_cnt_q != 3'(BEATS_IN - 1));

    ovf_sum = {1'b0, ovf_q} + 17'(beat_ovf);
    ovf_d   = ovf_q;
    if (hs_in) begin
      ovf_d = ovf_sum[16] ? 16'hFFFF : ovf_sum[15:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      acc_full_q  <= 1'b0;
      acc_last_q  <= 1'b0;
      obuf_q      <= '0;
      obuf_last_q <= 1'b0;
      in_cnt_q    <= '0;
      short_q     <= 1'b0;
      ovf_q       <= '0;
    end else begin
      acc_q       <= acc_d;
      acc_full_q  <= acc_full_d;
      acc_last_q  <= acc_last_d;
      obuf_q      <= obuf_d;
      obuf_last_q <= obuf_last_d;
      in_cnt_q    <= in_cnt_d;
      short_q     <= short_d;
      ovf_q       <= ovf_d;
    end
  end

  assign short_grp = short_q;
  assign ovf_cnt   = ovf_q;

  // Output FSM: state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      out_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      out_cnt_q <= out_cnt_d;
    end
  end

  // Output FSM: next state. A pending group restarts SEND at beat 0 without a gap.
  always_comb begin
    state_d   = state_q;
    out_cnt_d = out_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (xfer) begin
          state_d   = StSend;
          out_cnt_d = '0;
        end
      end
      StSend: begin
        if (hs_out) begin
          if (out_cnt_q == 3'(BEATS_OUT - 1)) begin
            out_cnt_d = '0;
            if (!xfer) begin
              state_d = StIdle;
            end
          end else begin
            out_cnt_d = 3'(out_cnt_q + 3'd1);
          end
        end
      end
      default: begin
        state_d   = StIdle;
        out_cnt_d = '0;
      end
    endcase
  end

  // Output FSM: outputs. Beat j carries the j-th 512-bit chunk from the top of the group.
  always_comb begin
    m_axis_tvalid = (state_q == StSend);
    m_axis_tlast  = m_axis_tvalid && obuf_last_q && (out_cnt_q == 3'(BEATS_OUT - 1));
    m_axis_tdata  = '0;
    if (m_axis_tvalid) begin
      for (int j = 0; j < int'(BEATS_OUT); j++) begin
        if (out_cnt_q == 3'(j)) begin
          m_axis_tdata = obuf_q[(int'(BEATS_OUT) - 1 - j)*int'(BEAT_W) +: BEAT_W];
        end
      end
    end
  end

endmodule
